// File: rtl/led_trail_fader.sv
// Comet-tail LED driver: lit channels pass straight through, released channels fade out via per-channel PWM.
// Optional LED_TRAIL_GAMMA_EN squares the brightness level before the PWM compare.
module led_trail_fader #(
    parameter int CH         = 8,
    parameter int PWM_W      = 8,
    parameter int DECAY_DIV  = 65536,
    parameter int DECAY_STEP = 8
) (
    input  logic          clk_50M,
    input  logic          rst,
    input  logic [CH-1:0] pattern_in,
    output logic [CH-1:0] dataout
);

    localparam int DIV_W = $clog2(DECAY_DIV);
    localparam logic [PWM_W-1:0] LVL_MAX  = '1;
    localparam logic [PWM_W-1:0] STEP     = PWM_W'(DECAY_STEP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);

    logic [CH-1:0]    pat_q;
    logic [CH-1:0]    dout_q, dout_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic [PWM_W-1:0] level_q [CH];
    logic [PWM_W-1:0] level_d [CH];

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        tick_d    = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick_d ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_comb begin : p_channel
        logic [PWM_W-1:0] eff;
        eff = '0;
        for (int i = 0; i < CH; i++) begin
            level_d[i] = level_q[i];
            if (!pat_q[i]) begin
                level_d[i] = LVL_MAX;
            end else if (tick_q) begin
                level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : '0;
            end

`ifdef LED_TRAIL_GAMMA_EN
            // Upper half of level^2 approximates perceived brightness.
            eff = PWM_W'(({{PWM_W{1'b0}}, level_q[i]} * {{PWM_W{1'b0}}, level_q[i]}) >> PWM_W);
`else
            eff = level_q[i];
`endif
            dout_d[i] = pat_q[i] ? !(pwm_cnt_q < eff) : 1'b0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            pat_q     <= '1;
            dout_q    <= '1;
            pwm_cnt_q <= '0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            pat_q     <= pattern_in;
            dout_q    <= dout_d;
            pwm_cnt_q <= pwm_cnt_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            for (int i = 0; i < CH; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign dataout = dout_q;

endmodule

// File: tb/tb_led_trail_fader.sv
// Randomized bench for led_trail_fader: a fast-decay instance checked every cycle against an
// arithmetic reference model, plus a slow-decay instance whose PWM duty is measured per period.
module tb_led_trail_fader;

    localparam int DIV  = 4;
    localparam int STEP = 64;
    localparam int SDIV  = 1024;
    localparam int SSTEP = 128;

    logic       clk_50M;
    logic       rst;
    logic [7:0] pat_main, pat_slow;
    logic [7:0] dout_main, dout_slow;

    int checks   = 0;
    int failures = 0;

    // reference model state: registered pattern, levels, outputs, edges since reset release
    logic [7:0] m_pat;
    int         m_lvl [8];
    logic [7:0] m_dout;
    int         n_edges;
    int         lows [10];

    led_trail_fader #(.CH(8), .PWM_W(8), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) u_main (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .pattern_in(pat_main),
        .dataout   (dout_main)
    );

    led_trail_fader #(.CH(8), .PWM_W(8), .DECAY_DIV(SDIV), .DECAY_STEP(SSTEP)) u_slow (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .pattern_in(pat_slow),
        .dataout   (dout_slow)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n_edges, got, exp);
        end
    endtask

    function automatic int eff_of(input int lv);
`ifdef LED_TRAIL_GAMMA_EN
        return (lv * lv) / 256;
`else
        return lv;
`endif
    endfunction

    task automatic model_reset();
        m_pat   = 8'hFF;
        m_dout  = 8'hFF;
        n_edges = 0;
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    endtask

    // One clock edge of the behavioural rules, using the state that held just before the edge.
    task automatic model_edge(input logic [7:0] pin);
        int pwm_now;
        bit tick_now;
        pwm_now  = n_edges % 256;
        tick_now = (n_edges >= DIV) && (n_edges % DIV == 0);
        for (int i = 0; i < 8; i++) begin
            m_dout[i] = (m_pat[i] == 1'b0) ? 1'b0 : !(pwm_now < eff_of(m_lvl[i]));
            if (m_pat[i] == 1'b0)  m_lvl[i] = 255;
            else if (tick_now)     m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
        end
        m_pat = pin;
        n_edges++;
    endtask

    // Called just after a negedge: drive, take one edge, compare at the next negedge.
    task automatic cycle(input logic [7:0] pm, input logic [7:0] ps);
        pat_main = pm;
        pat_slow = ps;
        @(posedge clk_50M);
        #1;
        model_edge(pm);
        @(negedge clk_50M);
        chk("dout_main", 32'(dout_main), 32'(m_dout));
        if (n_edges <= 2560) lows[(n_edges - 1) / 256] += (dout_slow[0] == 1'b0) ? 1 : 0;
    endtask

    initial begin
        logic [7:0] pat;
        for (int k = 0; k < 10; k++) lows[k] = 0;
        model_reset();
        rst      = 1'b0;
        pat_main = 8'h00;
        pat_slow = 8'h00;

        // reset held over three edges with every channel requested lit
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_50M);
            chk("rst_hold_main", 32'(dout_main), 32'hFF);
            chk("rst_hold_slow", 32'(dout_slow), 32'hFF);
        end
        rst = 1'b1;

        cycle(8'h00, 8'h00);
        chk("lat_edge1", 32'(dout_main), 32'hFF);
        cycle(8'h00, 8'h00);
        chk("lat_edge2", 32'(dout_main), 32'h00);

        // randomized patterns held for random spans; slow unit lit briefly then released
        pat = 8'hFF;
        for (int c = 3; c <= 2600; c++) begin
            if ($urandom_range(0, 11) == 0) pat = 8'($urandom | $urandom | $urandom);
            else if ($urandom_range(0, 30) == 0) pat = 8'hFF;
            cycle(pat, (c <= 8) ? 8'h00 : 8'hFF);
        end

        chk("duty_lvl255", 32'(lows[1]), 32'(eff_of(255)));
        chk("duty_lvl127", 32'(lows[5]), 32'(eff_of(127)));
        chk("duty_lvl0",   32'(lows[9]), 32'd0);

        // stagger releases so channels sit at different fade levels, then reset asynchronously
        cycle(8'h00, 8'hFF);
        cycle(8'h00, 8'hFF);
        for (int k = 0; k < 8; k++) cycle(8'hFF >> (7 - k), 8'hFF);
        #2 rst = 1'b0;
        #2;
        chk("async_rst_main", 32'(dout_main), 32'hFF);
        chk("async_rst_slow", 32'(dout_slow), 32'hFF);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk_50M);
        for (int k = 0; k < 300; k++) cycle(8'hFF, 8'hFF);
        chk("post_rst_dark", 32'(dout_main), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
